mem_arbiter_nway: RTL and testbench
===================================

// Module: mem_arbiter_nway
// PURPOSE
//  N-client arbiter between the L1 caches / prefetcher and the single cacheline adapter.
//  Generalises the fixed icache/dcache/prefetch arbiter to NUM_CLIENTS clients.
//  Parametrised line/address width; the granted request is latched so clients may not glitch it.
//  Fixed-priority or round-robin grant; one outstanding memory transaction at a time.
// PARAMETERS
//  NUM_CLIENTS  3    number of requesters (>=1); default map 0=icache, 1=dcache, 2=prefetch
//  ADDR_W       32   address width
//  LINE_W       256  cacheline width
//  IDX_W        localparam = (NUM_CLIENTS>1) ? $clog2(NUM_CLIENTS) : 1
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   reset
//  cli_read     in   NUM_CLIENTS         per-client read request, bit i = client i
//  cli_write    in   NUM_CLIENTS         per-client write request
//  cli_address  in   NUM_CLIENTS*ADDR_W  client i address at [i*ADDR_W +: ADDR_W]
//  cli_wdata    in   NUM_CLIENTS*LINE_W  client i write line at [i*LINE_W +: LINE_W]
//  cli_resp     out  NUM_CLIENTS         one-hot completion pulse to the granted client
//  cli_rdata    out  NUM_CLIENTS*LINE_W  read line; valid only for the granted client, zero elsewhere
//  mem_address  out  ADDR_W              latched address to the adapter
//  mem_read     out  1                   adapter read strobe, held until mem_resp
//  mem_write    out  1                   adapter write strobe, held until mem_resp
//  mem_wdata    out  LINE_W              latched write line
//  mem_resp     in   1                   adapter completion, single cycle
//  mem_rdata    in   LINE_W              adapter read line, valid with mem_resp
//  grant_id     out  IDX_W               index of the current/last granted client (debug)
//  busy         out  1                   high while in BUSY
// BEHAVIOUR
//  Reset: rst is synchronous and active-high; clock is clk.
//   - Reset sets the state to IDLE, grant_id=0 and the rr pointer to 0.
//   - After the reset edge all outputs are 0: mem_read, mem_write, cli_resp, cli_rdata, busy,
//     mem_address and mem_wdata.
//   - Reset mid-transaction abandons it; no cli_resp is issued for it.
//  FSM states: IDLE, BUSY.
//  IDLE:
//   - Candidates are clients with cli_read|cli_write.
//   - If any candidate exists, pick a winner (see CONFIGURATION).
//   - On the edge: latch address, wdata, op and grant_id, then go to BUSY.
//   - No candidate: stay in IDLE.
//   - mem_read, mem_write and cli_resp are all 0 in IDLE.
//  Op select: if a client asserts both cli_read and cli_write, the op is WRITE (illegal but defined).
//  BUSY:
//   - mem_read or mem_write = latched op; mem_address/mem_wdata come from the latches.
//   - Client inputs are ignored after the grant.
//   - cli_resp[grant_id] = mem_resp, combinationally, same cycle.
//   - cli_rdata for grant_id = mem_rdata; all other slices are 0.
//   - On mem_resp: go to IDLE. Otherwise stay in BUSY.
//  Latency:
//   - Request sampled in IDLE at cycle t -> mem strobe asserted at cycle t+1.
//   - mem_resp at cycle k -> cli_resp at cycle k.
//   - Earliest next grant is evaluated at k+1, giving 1 dead cycle between transactions.
//  Client rule: drop the request the cycle after cli_resp. A request still held at k+1 is a new request.
//  Simultaneous requests: exactly one grant per IDLE cycle; losers keep their request and wait.
//  mem_resp while IDLE is ignored. NUM_CLIENTS=1 degenerates to a pass-through with grant_id=0.
// CONFIGURATION
//  Macro ARB_ROUND_ROBIN_EN.
//  Undefined (fixed priority):
//   - The lowest index wins; default map gives icache > dcache > prefetch.
//  Defined (round-robin):
//   - The winner is the first candidate at or after rr_ptr, wrapping modulo NUM_CLIENTS.
//   - On each grant, rr_ptr <= (winner+1) mod NUM_CLIENTS.
//   - No client waits more than NUM_CLIENTS-1 grants.
// TESTING  (NUM_CLIENTS=3, 256-bit lines)
//  1. Reset: rst=1 for 2 cycles mid-BUSY -> mem_read=0, busy=0, cli_resp=0; a later mem_resp is ignored.
//  2. Single read:
//     - Stimulus: cli_read=3'b001, addr0=0x0000_1000; adapter returns rdata=0xA5.. after 5 cycles.
//     - Expect: mem_read at t+1, mem_address=0x1000, cli_resp=3'b001 for 1 cycle.
//     - Expect: slice0 of cli_rdata = 0xA5.., slices 1-2 = 0.
//  3. Write: cli_write=3'b010, addr1=0x2040, wdata1=0xDEAD.. -> mem_write=1, mem_wdata=0xDEAD.., cli_resp=3'b010.
//  4. Contention, fixed priority:
//     - Stimulus: all three request at the same cycle.
//     - Expect grant order 0,1,2; each subsequent grant starts 1 cycle after the previous cli_resp.
//  5. Contention, ARB_ROUND_ROBIN_EN defined:
//     - Stimulus: clients 0 and 2 hold requests continuously (re-request after each resp).
//     - Expect grant_id sequence 0,2,0,2; client 0 never wins twice in a row.
//  6. Input change: after the grant, change addr0 to 0xFFFF_0000 -> mem_address stays at the latched 0x1000 until mem_resp.

Source files
------------

// File: rtl/mem_arbiter_nway.sv
// N-client arbiter in front of a single cacheline memory adapter; one transaction in flight.
// Fixed priority (lowest index wins) by default; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter_nway #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  localparam int IDX_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_address,
  input  logic [NUM_CLIENTS*LINE_W-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]        cli_resp,
  output logic [NUM_CLIENTS*LINE_W-1:0] cli_rdata,
  output logic [ADDR_W-1:0]             mem_address,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_W-1:0]             mem_rdata,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state, state_nxt;
  logic [NUM_CLIENTS-1:0]   cand;
  logic                     any_req;
  logic                     take;
  logic [IDX_W-1:0]         winner;
  logic [ADDR_W-1:0]        addr_q;
  logic [LINE_W-1:0]        wdata_q;
  logic                     op_wr_q;
  logic [IDX_W-1:0]         grant_q;

  assign cand    = cli_read | cli_write;
  assign any_req = |cand;
  assign take    = (state == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // first candidate at or after rr_ptr, wrapping
  always_comb begin
    logic found;
    int   idx;
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int j = 0; j < NUM_CLIENTS; j++) begin
      idx = (int'(rr_ptr) + j) % NUM_CLIENTS;
      if (!found && cand[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (take)
      rr_ptr <= (winner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (cand[i]) winner = IDX_W'(i);
  end
`endif

  // request is captured at grant so clients cannot disturb the adapter mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      grant_q <= '0;
    end else if (take) begin
      addr_q  <= cli_address[winner*ADDR_W +: ADDR_W];
      wdata_q <= cli_wdata[winner*LINE_W +: LINE_W];
      op_wr_q <= cli_write[winner];
      grant_q <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req)  state_nxt = BUSY;
      BUSY: if (mem_resp) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    mem_read  = (state == BUSY) && !op_wr_q;
    mem_write = (state == BUSY) &&  op_wr_q;
    cli_resp  = '0;
    cli_rdata = '0;
    if (state == BUSY) begin
      cli_resp[grant_q]                    = mem_resp;
      cli_rdata[grant_q*LINE_W +: LINE_W]  = mem_rdata;
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arbiter_nway.sv
// Scoreboard bench for mem_arbiter_nway (3 clients, 256-bit lines); adapter modelled in serve().
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter_nway;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk, rst;
  logic [N-1:0]      cli_read, cli_write, cli_resp;
  logic [N*AW-1:0]   cli_address;
  logic [N*LW-1:0]   cli_wdata, cli_rdata;
  logic [AW-1:0]     mem_address;
  logic              mem_read, mem_write, mem_resp, busy;
  logic [LW-1:0]     mem_wdata, mem_rdata;
  logic [1:0]        grant_id;

  typedef struct {
    int            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_nway #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cli_read(cli_read), .cli_write(cli_write),
    .cli_address(cli_address), .cli_wdata(cli_wdata),
    .cli_resp(cli_resp), .cli_rdata(cli_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int id, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    cli_read[id]            = rd;
    cli_write[id]           = wr;
    cli_address[id*AW +: AW] = a;
    cli_wdata[id*LW +: LW]   = d;
  endtask

  task automatic expect_txn(input int id, input bit wr,
                            input logic [AW-1:0] a, input logic [LW-1:0] d);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cli_read = '0; cli_write = '0; mem_resp = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Wait for the next strobe, compare against the scoreboard head, hold `delay` cycles, respond.
  task automatic serve(input int exp_wait, input int delay, input logic [LW-1:0] rd,
                       input bit rerequest);
    int            cnt;
    txn_t          t;
    logic [N-1:0]  exp_resp;
    logic [N*LW-1:0] exp_rdata;
    cnt = 0;
    #1;
    while (!(mem_read || mem_write) && cnt < 50) begin
      @(negedge clk); #1; cnt++;
    end
    checks++;
    if (cnt >= 50) begin
      errors++; $display("FAIL strobe_timeout: no mem strobe within 50 cycles");
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL unexpected_grant: grant_id=%0d with empty scoreboard", grant_id);
      return;
    end
    t = exp_q.pop_front();
    if (exp_wait >= 0) begin
      checks++;
      if (cnt !== exp_wait) begin
        errors++; $display("FAIL grant_latency: got %0d cycles exp %0d", cnt, exp_wait);
      end
    end
    checks++;
    if (grant_id !== 2'(t.id)) begin
      errors++; $display("FAIL grant_id: got %0d exp %0d", grant_id, t.id);
    end
    checks++;
    if (mem_write !== t.wr || mem_read !== !t.wr) begin
      errors++; $display("FAIL mem_op: got rd=%0b wr=%0b exp wr=%0b", mem_read, mem_write, t.wr);
    end
    checks++;
    if (mem_address !== t.addr) begin
      errors++; $display("FAIL mem_address: got %h exp %h", mem_address, t.addr);
    end
    if (t.wr) begin
      checks++;
      if (mem_wdata !== t.wdata) begin
        errors++; $display("FAIL mem_wdata: got %h exp %h", mem_wdata, t.wdata);
      end
    end
    // client changes its inputs after the grant; the adapter side must not follow
    cli_address[t.id*AW +: AW] = ~t.addr;
    cli_wdata[t.id*LW +: LW]   = ~t.wdata;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_address !== t.addr || mem_wdata !== t.wdata || busy !== 1'b1 || cli_resp !== '0) begin
        errors++;
        $display("FAIL hold: addr=%h exp %h busy=%0b cli_resp=%b", mem_address, t.addr, busy, cli_resp);
      end
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = rd;
    cli_address[t.id*AW +: AW] = t.addr;
    cli_wdata[t.id*LW +: LW]   = t.wdata;
    #1;
    exp_resp = '0;  exp_resp[t.id] = 1'b1;
    exp_rdata = '0; exp_rdata[t.id*LW +: LW] = rd;
    checks++;
    if (cli_resp !== exp_resp) begin
      errors++; $display("FAIL cli_resp: got %b exp %b", cli_resp, exp_resp);
    end
    checks++;
    if (cli_rdata !== exp_rdata) begin
      errors++; $display("FAIL cli_rdata: got %h exp %h", cli_rdata, exp_rdata);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    if (!rerequest) begin
      cli_read[t.id] = 1'b0; cli_write[t.id] = 1'b0;
    end
    #1;
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || cli_resp !== '0) begin
      errors++;
      $display("FAIL dead_cycle: busy=%0b rd=%0b wr=%0b resp=%b", busy, mem_read, mem_write, cli_resp);
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; cli_read = '0; cli_write = '0; cli_address = '0; cli_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, busy} !== 3'b000 || cli_resp !== '0 || cli_rdata !== '0 ||
        mem_address !== '0 || mem_wdata !== '0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: rd=%0b wr=%0b busy=%0b resp=%b addr=%h gid=%0d",
               mem_read, mem_write, busy, cli_resp, mem_address, grant_id);
    end
    // reset in the middle of a transaction from client 1
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h0000_3000, '0);
    cnt = 0;
    #1;
    while (!mem_read && cnt < 20) begin @(negedge clk); #1; cnt++; end
    checks++;
    if (!mem_read) begin
      errors++; $display("FAIL reset_setup: mem_read=%0b exp 1", mem_read);
    end
    @(negedge clk);
    rst = 1'b1; cli_read = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || cli_resp !== '0 || grant_id !== 2'd0 ||
        mem_address !== '0) begin
      errors++;
      $display("FAIL reset_midbusy: rd=%0b busy=%0b resp=%b gid=%0d addr=%h",
               mem_read, busy, cli_resp, grant_id, mem_address);
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = rand_line();
    #1;
    checks++;
    if (cli_resp !== '0 || cli_rdata !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_resp: resp=%b busy=%0b exp 0", cli_resp, busy);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL idle_resp_after: busy=%0b rd=%0b wr=%0b", busy, mem_read, mem_write);
    end
  endtask

  task automatic test_single_read();
    logic [LW-1:0] rd;
    rd = {8{32'hA5A5_A5A5}};
    @(negedge clk);
    expect_txn(0, 1'b0, 32'h0000_1000, '0);
    set_req(0, 1'b1, 1'b0, 32'h0000_1000, '0);
    serve(1, 5, rd, 1'b0);
  endtask

  task automatic test_write();
    logic [LW-1:0] wd;
    wd = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    expect_txn(1, 1'b1, 32'h0000_2040, wd);
    set_req(1, 1'b0, 1'b1, 32'h0000_2040, wd);
    serve(1, 3, rand_line(), 1'b0);
  endtask

  task automatic test_read_and_write();
    logic [LW-1:0] wd;
    wd = rand_line();
    @(negedge clk);
    expect_txn(2, 1'b1, 32'h0000_4080, wd);
    set_req(2, 1'b1, 1'b1, 32'h0000_4080, wd);
    serve(1, 1, rand_line(), 1'b0);
  endtask

  task automatic test_contention();
    logic [LW-1:0] wd;
    apply_reset();
    wd = rand_line();
    expect_txn(0, 1'b0, 32'h0001_0000, '0);
    expect_txn(1, 1'b1, 32'h0001_1000, wd);
    expect_txn(2, 1'b0, 32'h0001_2000, '0);
    set_req(0, 1'b1, 1'b0, 32'h0001_0000, '0);
    set_req(1, 1'b0, 1'b1, 32'h0001_1000, wd);
    set_req(2, 1'b1, 1'b0, 32'h0001_2000, '0);
    serve(1, 2, rand_line(), 1'b0);
    serve(1, 0, rand_line(), 1'b0);
    serve(1, 4, rand_line(), 1'b0);
  endtask

  task automatic test_two_holders();
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    expect_txn(0, 1'b0, 32'h0002_0000, '0);
    expect_txn(2, 1'b0, 32'h0002_2000, '0);
    expect_txn(0, 1'b0, 32'h0002_0000, '0);
    expect_txn(2, 1'b0, 32'h0002_2000, '0);
`else
    expect_txn(0, 1'b0, 32'h0002_0000, '0);
    expect_txn(0, 1'b0, 32'h0002_0000, '0);
    expect_txn(0, 1'b0, 32'h0002_0000, '0);
    expect_txn(2, 1'b0, 32'h0002_2000, '0);
`endif
    set_req(0, 1'b1, 1'b0, 32'h0002_0000, '0);
    set_req(2, 1'b1, 1'b0, 32'h0002_2000, '0);
    serve(1, 1, rand_line(), 1'b1);
    serve(1, 1, rand_line(), 1'b1);
    serve(1, 1, rand_line(), 1'b0);
    serve(1, 1, rand_line(), 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_read_and_write();
    test_contention();
    test_two_holders();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
